// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - scanned 4x4 matrix keypad reader with press/release debounce
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_pressed
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] DEB_TERM = CW'(DEBOUNCE_CNT);
    localparam logic [31:0]   TIMER_TERM = 32'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [3:0]    row_meta, row_s;
    logic [31:0]   timer;
    logic          tick;
    logic [1:0]    col_idx, col_next;
    logic [1:0]    row_idx, row_next;
    logic [1:0]    row_low;
    logic [CW-1:0] deb_cnt, deb_next;
    logic [CW-1:0] rel_cnt, rel_next;
    logic          accept;
    logic          release_key;

    assign tick  = (timer == TIMER_TERM);
    assign o_col = ~(4'b0001 << col_idx);

    always_comb begin
        row_low = 2'd3;
        if (!row_s[0])      row_low = 2'd0;
        else if (!row_s[1]) row_low = 2'd1;
        else if (!row_s[2]) row_low = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hf;
            row_s    <= 4'hf;
            timer    <= '0;
        end else begin
            row_meta <= i_row;
            row_s    <= row_meta;
            timer    <= tick ? '0 : timer + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SCAN;
            col_idx       <= '0;
            row_idx       <= '0;
            deb_cnt       <= '0;
            rel_cnt       <= '0;
            o_key_code    <= '0;
            o_key_valid   <= 1'b0;
            o_key_pressed <= 1'b0;
        end else begin
            state       <= state_next;
            col_idx     <= col_next;
            row_idx     <= row_next;
            deb_cnt     <= deb_next;
            rel_cnt     <= rel_next;
            o_key_valid <= accept;
            if (accept) begin
                o_key_code    <= {row_next, col_idx};
                o_key_pressed <= 1'b1;
            end else if (release_key) begin
                o_key_pressed <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        col_next    = col_idx;
        row_next    = row_idx;
        deb_next    = deb_cnt;
        rel_next    = rel_cnt;
        accept      = 1'b0;
        release_key = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s == 4'hf) begin
                        col_next = col_idx + 2'd1;
                    end else begin
                        row_next = row_low;
                        // A single-sample debounce accepts on the detecting tick itself.
                        if (DEBOUNCE_CNT == 1) begin
                            deb_next   = '0;
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            deb_next   = CW'(1);
                            state_next = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_s[row_idx]) begin
                        if (deb_cnt + CW'(1) == DEB_TERM) begin
                            deb_next   = '0;
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            deb_next = deb_cnt + CW'(1);
                        end
                    end else begin
                        deb_next   = '0;
                        col_next   = col_idx + 2'd1;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (row_s[row_idx]) begin
                        if (rel_cnt + CW'(1) == DEB_TERM) begin
                            rel_next    = '0;
                            release_key = 1'b1;
                            col_next    = col_idx + 2'd1;
                            state_next  = SCAN;
                        end else begin
                            rel_next = rel_cnt + CW'(1);
                        end
                    end else begin
                        rel_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_row;
    logic [3:0] o_col;
    logic [3:0] o_key_code;
    logic       o_key_valid;
    logic       o_key_pressed;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    logic [3:0] exp_q[$];

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_row        (i_row),
        .o_col        (o_col),
        .o_key_code   (o_key_code),
        .o_key_valid  (o_key_valid),
        .o_key_pressed(o_key_pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One slot is 4 clocks; inputs change on slot boundaries so the next tick samples them.
    task automatic slots(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_row = 4'hf;
        fork
            forever begin
                @(negedge clk);
                if (rst_n && o_key_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 4'(o_key_valid), 4'd0);
                    end else begin
                        check("key_code", o_key_code, exp_q.pop_front());
                        check("pressed_at_valid", 4'(o_key_pressed), 4'd1);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_col", o_col, 4'b1110);
        check("rst_code", o_key_code, 4'h0);
        check("rst_valid", 4'(o_key_valid), 4'd0);
        check("rst_pressed", 4'(o_key_pressed), 4'd0);
        rst_n = 1'b1;

        // b0..b4: idle rotation
        repeat (3) @(negedge clk);
        check("idle_col_hold", o_col, 4'b1110);
        @(negedge clk);
        check("idle_col1", o_col, 4'b1101);
        slots(1); check("idle_col2", o_col, 4'b1011);
        slots(1); check("idle_col3", o_col, 4'b0111);
        slots(1); check("idle_col0", o_col, 4'b1110);

        // b5: row 2 at col 1 for 5 slots
        slots(1);
        check("s2_col1", o_col, 4'b1101);
        exp_q.push_back(4'b1001);
        i_row = 4'b1011;
        slots(4);
        check("s2_code", o_key_code, 4'b1001);
        check("s2_pulse_once", 4'(o_key_valid), 4'd0);
        check("s2_pressed", 4'(o_key_pressed), 4'd1);
        slots(1);
        i_row = 4'hf;
        slots(2);
        check("s2_hold_pressed", 4'(o_key_pressed), 4'd1);
        check("s2_hold_col", o_col, 4'b1101);
        slots(1);
        check("s2_rel_pressed", 4'(o_key_pressed), 4'd0);
        check("s2_rel_col", o_col, 4'b1011);

        // b14: glitch on row 0 at col 3
        slots(1);
        check("s3_col3", o_col, 4'b0111);
        i_row = 4'b1110;
        slots(2);
        check("s3_frozen", o_col, 4'b0111);
        i_row = 4'hf;
        slots(1);
        check("s3_resume", o_col, 4'b1110);
        check("s3_pressed", 4'(o_key_pressed), 4'd0);

        // b17: rows 1 and 3 at col 0, then release/re-press inside HELD
        exp_q.push_back(4'b0100);
        i_row = 4'b0101;
        slots(4);
        check("s4_code", o_key_code, 4'b0100);
        check("s4_pressed", 4'(o_key_pressed), 4'd1);
        i_row = 4'b1101;
        slots(1);
        i_row = 4'hf;
        slots(2);
        i_row = 4'b1101;
        slots(1);
        i_row = 4'hf;
        slots(2);
        check("s5_still_pressed", 4'(o_key_pressed), 4'd1);
        check("s5_col_frozen", o_col, 4'b1110);
        slots(1);
        check("s5_released", 4'(o_key_pressed), 4'd0);
        check("s5_col_next", o_col, 4'b1101);

        // b28: reset in the middle of a debounce
        i_row = 4'b1110;
        slots(2);
        rst_n = 1'b0;
        #1;
        check("s6_rst_col", o_col, 4'b1110);
        check("s6_rst_code", o_key_code, 4'h0);
        check("s6_rst_valid", 4'(o_key_valid), 4'd0);
        check("s6_rst_pressed", 4'(o_key_pressed), 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b0000);
        slots(1);
        check("s6_deb1_pressed", 4'(o_key_pressed), 4'd0);
        check("s6_deb1_col", o_col, 4'b1110);
        slots(1);
        check("s6_deb2_pressed", 4'(o_key_pressed), 4'd0);
        slots(1);
        check("s6_accept_pressed", 4'(o_key_pressed), 4'd1);
        i_row = 4'hf;
        slots(3);
        check("s6_released", 4'(o_key_pressed), 4'd0);
        check("s6_col_next", o_col, 4'b1101);

        slots(2);
        check("valid_count", 4'(n_valid), 4'd3);
        check("queue_empty", 4'(exp_q.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scanned 4x4 matrix keypad reader; the input-side counterpart of the multiplexed seven-segment display driver.
- Rotates an active-low column strobe and samples active-low row returns.
- Debounces press and release, then reports one key code per press.
- Sits beside the display path and feeds time-set and mode logic in the top level.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot (1 kHz slot rate at 50 MHz); legal range >= 2.
- DEBOUNCE_CNT, 20: consecutive matching slot samples required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- i_row  input  4  keypad row returns, active-low, externally pulled up, asynchronous to clk.
- o_col  output  4  column strobe, active-low, exactly one bit low at all times.
- o_key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- o_key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- o_key_pressed  output  1  high while an accepted key is held, until its release is debounced.

Behaviour:
- Reset values: o_col=4'b1110 (col_idx 0), o_key_code=0, o_key_valid=0, o_key_pressed=0, FSM=SCAN, all counters 0.
- Reset is asynchronous and can occur mid-debounce or mid-hold; it returns every state and output to its reset value immediately.
- Synchronizer: i_row passes through a 2-flop synchronizer (row_s). All decisions use row_s only.
- Slot timer: free-runs 0..SCAN_DIV-1 in every state and wraps to 0. tick=1 on the cycle the timer equals SCAN_DIV-1. All sampling happens on tick cycles only.
- Column drive: o_col = ~(4'b0001 << col_idx).
- SCAN state:
  - On tick with row_s==4'b1111: col_idx increments mod 4 (3 wraps to 0); stay in SCAN.
  - On tick with any row_s bit low: capture row_idx as the lowest-index low bit and keep col_idx unchanged. Set deb_cnt=1; go to DEBOUNCE, or go straight to HELD if DEBOUNCE_CNT==1.
- DEBOUNCE state (col_idx frozen):
  - On tick with row_s[row_idx]==0: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_CNT: go to HELD.
  - On tick with row_s[row_idx]==1: deb_cnt=0; col_idx increments mod 4; go to SCAN. No output change.
- Acceptance (entry to HELD):
  - o_key_code={row_idx,col_idx} is registered on the cycle after the accepting tick.
  - o_key_valid is high for exactly that one cycle.
  - o_key_pressed goes to 1 on that same cycle.
  - o_key_code holds its value until the next acceptance.
- HELD state (col_idx frozen):
  - On tick with row_s[row_idx]==1: rel_cnt++.
  - On tick with row_s[row_idx]==0: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_CNT: o_key_pressed=0 on the next cycle; rel_cnt=0; col_idx increments mod 4; go to SCAN.
- Multiple keys:
  - A second key pressed while in DEBOUNCE or HELD is ignored. No rollover, no ghost rejection.
  - Simultaneous keys in one column: lowest row wins.
- Glitches: a press shorter than DEBOUNCE_CNT slots never produces o_key_valid.
- Latency, stable press in the current column: (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycles from the first detecting tick to o_key_valid, plus 2 synchronizer cycles from the pin.
- Widths: timer 32 bits; deb_cnt and rel_cnt sized for DEBOUNCE_CNT; no overflow, because both counters saturate at terminal and then clear.

Test Plan:
- Settings for all scenarios: SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset then idle (i_row=4'b1111): o_col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 clks; o_key_valid is never asserted.
- Hold row 2 low while col 1 is strobed, for 5 slots: single o_key_valid pulse with o_key_code=4'b1001 and o_key_pressed=1. o_col stays 1101 until release is debounced 3 slots after row 2 goes high, then advances to 1011.
- Row 0 low for only 2 slots at col 3: no o_key_valid; SCAN resumes with o_col=1110.
- Rows 1 and 3 low together at col 0: o_key_code=4'b0100; raising row 3 mid-hold causes no new pulse.
- During HELD, release for 2 slots, press again for 1 slot, then release for 3 slots: o_key_pressed stays 1 until the final 3-slot release; exactly one o_key_valid pulse in total.
- rst_n low mid-DEBOUNCE: all outputs at reset values immediately. After release, a fresh full debounce is required before any o_key_valid.
